// File: rtl/mcu_el2_ccm_bank_sram.sv
// Banked CCM SRAM sink: per-bank reads with RD_LAT-cycle latency, writes on the clock edge, and a zeroization FSM.
// Latency: reads take RD_LAT cycles and writes take effect at the edge. There is no backpressure; accesses issued during INIT are dropped and flagged.
module mcu_el2_ccm_bank_sram #(
    parameter int              NUM_BANKS     = 4,
    parameter int              ADDR_W        = 10,
    parameter int              DATA_W        = 39,
    parameter int              RD_LAT        = 1,
    parameter int              INIT_ON_RESET = 1,
    parameter logic [DATA_W-1:0] INIT_VALUE  = '0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_BANKS-1:0]        clken,
    input  logic [NUM_BANKS-1:0]        wren,
    input  logic [NUM_BANKS*ADDR_W-1:0] addr,
    input  logic [NUM_BANKS*DATA_W-1:0] wdata,
    output logic [NUM_BANKS*DATA_W-1:0] rdata,
    output logic [NUM_BANKS-1:0]        rd_valid,
    input  logic                        init_req,
    output logic                        init_busy,
    output logic                        init_done,
    output logic                        acc_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_INIT = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                boot_q;
    logic [ADDR_W:0]     cnt_q, cnt_d, cnt_inc;
    logic                acc_err_q;
    logic                in_init;
    logic [NUM_BANKS-1:0] rd_acc;

    logic [DATA_W-1:0]    mem_q      [NUM_BANKS][2**ADDR_W];
    logic [DATA_W-1:0]    pipe_dat_q [RD_LAT][NUM_BANKS];
    logic [NUM_BANKS-1:0] pipe_vld_q [RD_LAT];

    assign in_init = (state_q == ST_INIT);
    assign rd_acc  = clken & ~wren & {NUM_BANKS{~in_init}};

    // boot_q is high for the first cycle after reset, so the power-up INIT starts only once rst is released.
    always_comb begin
        state_d = state_q;
        cnt_inc = cnt_q + {{ADDR_W{1'b0}}, 1'b1};
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: if ((boot_q && (INIT_ON_RESET != 0)) || init_req) state_d = ST_INIT;
            ST_DONE: if (init_req) state_d = ST_INIT;
            ST_INIT: begin
                cnt_d = cnt_inc;
                if (cnt_inc[ADDR_W]) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            boot_q    <= 1'b1;
            cnt_q     <= '0;
            acc_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            boot_q    <= 1'b0;
            cnt_q     <= cnt_d;
            acc_err_q <= in_init && (|clken);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (in_init)
                    mem_q[b][cnt_q[ADDR_W-1:0]] <= INIT_VALUE;
                else if (clken[b] && wren[b])
                    mem_q[b][addr[b*ADDR_W +: ADDR_W]] <= wdata[b*DATA_W +: DATA_W];
            end
        end
    end

    // Each stage loads data only when its valid bit arrives, so the final stage holds the last read word.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < RD_LAT; s++) begin
                pipe_vld_q[s] <= '0;
                for (int b = 0; b < NUM_BANKS; b++) pipe_dat_q[s][b] <= '0;
            end
        end else begin
            pipe_vld_q[0] <= rd_acc;
            for (int b = 0; b < NUM_BANKS; b++)
                if (rd_acc[b]) pipe_dat_q[0][b] <= mem_q[b][addr[b*ADDR_W +: ADDR_W]];
            for (int s = 1; s < RD_LAT; s++) begin
                pipe_vld_q[s] <= pipe_vld_q[s-1];
                for (int b = 0; b < NUM_BANKS; b++)
                    if (pipe_vld_q[s-1][b]) pipe_dat_q[s][b] <= pipe_dat_q[s-1][b];
            end
        end
    end

    always_comb begin
        rdata = '0;
        for (int b = 0; b < NUM_BANKS; b++)
            rdata[b*DATA_W +: DATA_W] = pipe_dat_q[RD_LAT-1][b];
    end

    assign rd_valid  = pipe_vld_q[RD_LAT-1];
    assign init_busy = in_init;
    assign init_done = (state_q == ST_DONE);
    assign acc_err   = acc_err_q;

endmodule

// File: tb/tb_mcu_el2_ccm_bank_sram.sv
// Directed bench for mcu_el2_ccm_bank_sram: three instances covering RD_LAT=1, RD_LAT=3, and power-up without INIT.
module tb_mcu_el2_ccm_bank_sram;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   clken, wren;
    logic [15:0]  addr;
    logic [155:0] wdata;
    logic         init_req, init_req_n;

    logic [155:0] rdata, rdata_l3, rdata_n;
    logic [3:0]   rd_valid, rd_valid_l3, rd_valid_n;
    logic         init_busy, init_busy_l3, init_busy_n;
    logic         init_done, init_done_l3, init_done_n;
    logic         acc_err, acc_err_l3, acc_err_n;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mcu_el2_ccm_bank_sram #(.ADDR_W(4), .RD_LAT(1), .INIT_ON_RESET(1)) dut (
        .clk(clk), .rst(rst), .clken(clken), .wren(wren), .addr(addr), .wdata(wdata),
        .rdata(rdata), .rd_valid(rd_valid), .init_req(init_req), .init_busy(init_busy),
        .init_done(init_done), .acc_err(acc_err));

    mcu_el2_ccm_bank_sram #(.ADDR_W(4), .RD_LAT(3), .INIT_ON_RESET(1)) dut_l3 (
        .clk(clk), .rst(rst), .clken(clken), .wren(wren), .addr(addr), .wdata(wdata),
        .rdata(rdata_l3), .rd_valid(rd_valid_l3), .init_req(init_req), .init_busy(init_busy_l3),
        .init_done(init_done_l3), .acc_err(acc_err_l3));

    mcu_el2_ccm_bank_sram #(.ADDR_W(4), .RD_LAT(1), .INIT_ON_RESET(0)) dut_n (
        .clk(clk), .rst(rst), .clken(clken), .wren(wren), .addr(addr), .wdata(wdata),
        .rdata(rdata_n), .rd_valid(rd_valid_n), .init_req(init_req_n), .init_busy(init_busy_n),
        .init_done(init_done_n), .acc_err(acc_err_n));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drv_idle;
        clken = '0;
        wren  = '0;
    endtask

    task automatic drv_rd(input int b, input logic [3:0] a);
        clken[b] = 1'b1;
        wren[b]  = 1'b0;
        addr[b*4 +: 4] = a;
    endtask

    task automatic drv_wr(input int b, input logic [3:0] a, input logic [38:0] d);
        clken[b] = 1'b1;
        wren[b]  = 1'b1;
        addr[b*4 +: 4] = a;
        wdata[b*39 +: 39] = d;
    endtask

    task automatic test_reset;
        rst = 1'b1; init_req = 1'b0; init_req_n = 1'b0;
        addr = '0; wdata = '0; drv_idle();
        repeat (3) tick();
        vectors++;
        if ({rdata, rd_valid, init_busy, init_done, acc_err} !== '0) begin
            miscompares++;
            $display("FAIL reset_dut: got rdata=%h vld=%b busy=%b done=%b err=%b, want all 0", rdata, rd_valid, init_busy, init_done, acc_err);
        end
        vectors++;
        if ({rdata_l3, rd_valid_l3, init_busy_l3, init_done_l3, acc_err_l3} !== '0) begin
            miscompares++;
            $display("FAIL reset_l3: got vld=%b busy=%b done=%b err=%b, want all 0", rd_valid_l3, init_busy_l3, init_done_l3, acc_err_l3);
        end
    endtask

    task automatic test_power_init;
        int n;
        rst = 1'b0;
        tick();
        vectors++;
        if ({init_busy, init_done, init_busy_l3} !== 3'b101) begin
            miscompares++;
            $display("FAIL power_init_entry: got busy=%b done=%b busy_l3=%b, want 1 0 1", init_busy, init_done, init_busy_l3);
        end
        n = 0;
        while (init_busy && n < 100) begin n++; tick(); end
        vectors++;
        if (n !== 16 || init_done !== 1'b1) begin
            miscompares++;
            $display("FAIL power_init_len: got %0d cycles done=%b, want 16 cycles done=1", n, init_done);
        end
        vectors++;
        if ({init_busy_n, init_done_n} !== 2'b00) begin
            miscompares++;
            $display("FAIL noinit_idle_after_reset: got busy=%b done=%b, want 0 0", init_busy_n, init_done_n);
        end
        drv_rd(2, 4'hF);
        tick();
        drv_idle();
        vectors++;
        if (rd_valid !== 4'b0100 || rdata[2*39 +: 39] !== 39'h0) begin
            miscompares++;
            $display("FAIL zeroized_read: got vld=%b data=%h, want 0100 0", rd_valid, rdata[2*39 +: 39]);
        end
        tick();
        vectors++;
        if (rd_valid !== 4'b0000) begin
            miscompares++;
            $display("FAIL rd_valid_pulse: got %b, want 0000", rd_valid);
        end
    endtask

    task automatic test_latency;
        logic [38:0] exp_d;
        logic        exp_v;
        drv_wr(1, 4'h3, 39'h5A5A5A5A5);
        tick();
        drv_wr(1, 4'h8, 39'h123456789);
        tick();
        drv_idle();
        drv_rd(1, 4'h3);
        for (int i = 1; i <= 5; i++) begin
            tick();
            drv_idle();
            exp_v = (i == 3);
            exp_d = (i >= 3) ? 39'h5A5A5A5A5 : 39'h0;
            vectors++;
            if (rd_valid_l3[1] !== exp_v || rdata_l3[39 +: 39] !== exp_d) begin
                miscompares++;
                $display("FAIL latency3_cyc%0d: got vld=%b data=%h, want %b %h", i, rd_valid_l3[1], rdata_l3[39 +: 39], exp_v, exp_d);
            end
        end
    endtask

    task automatic test_parallel;
        drv_wr(3, 4'h2, 39'h0333333333);
        tick();
        drv_idle();
        drv_wr(0, 4'h9, 39'h4000000001);
        drv_rd(3, 4'h2);
        tick();
        drv_idle();
        vectors++;
        if (rd_valid !== 4'b1000 || rdata[3*39 +: 39] !== 39'h0333333333) begin
            miscompares++;
            $display("FAIL parallel_rd3: got vld=%b data=%h, want 1000 0333333333", rd_valid, rdata[3*39 +: 39]);
        end
        drv_rd(0, 4'h9);
        tick();
        drv_idle();
        vectors++;
        if (rd_valid !== 4'b0001 || rdata[0 +: 39] !== 39'h4000000001 || rdata[3*39 +: 39] !== 39'h0333333333) begin
            miscompares++;
            $display("FAIL parallel_wr0: got vld=%b d0=%h d3=%h, want 0001 4000000001 0333333333", rd_valid, rdata[0 +: 39], rdata[3*39 +: 39]);
        end
    endtask

    task automatic test_back_to_back;
        logic [38:0] vals [3];
        vals[0] = 39'h0011111111; vals[1] = 39'h2222222222; vals[2] = 39'h7FFFFFFFFF;
        for (int i = 0; i < 3; i++) begin
            drv_wr(2, 4'(4 + i), vals[i]);
            tick();
        end
        drv_idle();
        for (int i = 0; i < 3; i++) begin
            drv_rd(2, 4'(4 + i));
            tick();
            vectors++;
            if (rd_valid !== 4'b0100 || rdata[2*39 +: 39] !== vals[i]) begin
                miscompares++;
                $display("FAIL b2b_rd%0d: got vld=%b data=%h, want 0100 %h", i, rd_valid, rdata[2*39 +: 39], vals[i]);
            end
        end
        drv_idle();
        tick();
        vectors++;
        if (rd_valid !== 4'b0000 || rdata[2*39 +: 39] !== vals[2]) begin
            miscompares++;
            $display("FAIL b2b_hold: got vld=%b data=%h, want 0000 %h", rd_valid, rdata[2*39 +: 39], vals[2]);
        end
        drv_wr(2, 4'h7, 39'h55AA55AA55);
        tick();
        drv_idle();
        drv_rd(2, 4'h7);
        tick();
        drv_idle();
        vectors++;
        if (rd_valid !== 4'b0100 || rdata[2*39 +: 39] !== 39'h55AA55AA55) begin
            miscompares++;
            $display("FAIL wr_then_rd: got vld=%b data=%h, want 0100 55AA55AA55", rd_valid, rdata[2*39 +: 39]);
        end
    endtask

    task automatic test_access_during_init;
        int n;
        init_req = 1'b1;
        drv_rd(1, 4'h8);
        tick();
        init_req = 1'b0;
        vectors++;
        if ({init_busy, init_done, rd_valid} !== 6'b10_0010) begin
            miscompares++;
            $display("FAIL init_entry: got busy=%b done=%b vld=%b, want 1 0 0010", init_busy, init_done, rd_valid);
        end
        clken = 4'b0011;
        wren  = 4'b0000;
        n = 0;
        while (init_busy && n < 100) begin
            n++;
            tick();
            if (n == 1) begin
                drv_idle();
                vectors++;
                if (acc_err !== 1'b1 || rd_valid !== 4'b0000) begin
                    miscompares++;
                    $display("FAIL acc_err_pulse: got err=%b vld=%b, want 1 0000", acc_err, rd_valid);
                end
            end
            if (n == 2) begin
                vectors++;
                if (acc_err !== 1'b0 || rd_valid !== 4'b0000) begin
                    miscompares++;
                    $display("FAIL acc_err_single: got err=%b vld=%b, want 0 0000", acc_err, rd_valid);
                end
                vectors++;
                if (rd_valid_l3 !== 4'b0010 || rdata_l3[39 +: 39] !== 39'h123456789) begin
                    miscompares++;
                    $display("FAIL inflight_rd: got vld=%b data=%h, want 0010 123456789", rd_valid_l3, rdata_l3[39 +: 39]);
                end
            end
        end
        vectors++;
        if (n !== 16 || init_done !== 1'b1) begin
            miscompares++;
            $display("FAIL init_len_with_access: got %0d cycles done=%b, want 16 1", n, init_done);
        end
    endtask

    task automatic test_reset_mid_init;
        int n;
        init_req = 1'b1;
        tick();
        init_req = 1'b0;
        repeat (7) tick();
        rst = 1'b1;
        tick();
        vectors++;
        if ({init_busy, init_done} !== 2'b00) begin
            miscompares++;
            $display("FAIL mid_init_reset: got busy=%b done=%b, want 0 0", init_busy, init_done);
        end
        rst = 1'b0;
        tick();
        n = 0;
        while (init_busy && n < 100) begin
            n++;
            tick();
        end
        vectors++;
        if (n !== 16 || init_done !== 1'b1) begin
            miscompares++;
            $display("FAIL restart_len: got %0d cycles done=%b, want 16 1", n, init_done);
        end
    endtask

    task automatic test_noinit;
        int n;
        repeat (3) tick();
        vectors++;
        if ({init_busy_n, init_done_n} !== 2'b00) begin
            miscompares++;
            $display("FAIL noinit_stays_idle: got busy=%b done=%b, want 0 0", init_busy_n, init_done_n);
        end
        init_req_n = 1'b1;
        tick();
        init_req_n = 1'b0;
        n = 0;
        while (init_busy_n && n < 100) begin
            n++;
            tick();
        end
        vectors++;
        if (n !== 16 || init_done_n !== 1'b1) begin
            miscompares++;
            $display("FAIL noinit_req_len: got %0d cycles done=%b, want 16 1", n, init_done_n);
        end
    endtask

    initial begin
        test_reset();
        test_power_init();
        test_latency();
        test_parallel();
        test_back_to_back();
        test_access_during_init();
        test_reset_mid_init();
        test_noinit();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
